// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer backed by a byte-addressed local memory.
//
// It inserts a programmable number of wait states, writes byte lanes under
// PSTRB control, and answers PSLVERR for out-of-range or misaligned accesses.
//
// Optional build macro:
//   APB_SLV_PROT_CHECK_EN - when defined, a nonsecure access (pprot[1]=1)
//                           to an offset below SECURE_BYTES is rejected
//                           with PSLVERR.
//
// Ports:
//   pclk      in   APB clock; all state updates on the rising edge
//   preset    in   asynchronous, active-high reset
//   psel      in   slave select
//   penable   in   access phase indicator
//   pwrite    in   1 = write, 0 = read
//   paddr     in   byte address
//   pwdata    in   write data
//   pstrb     in   write byte strobes
//   pprot     in   protection type
//   wait_cfg  in   wait states to insert (0..15), sampled in the setup phase
//   prdata    out  read data, nonzero only while pready=1 on a good read
//   pready    out  transfer completion
//   pslverr   out  error response, only while pready=1
module apb_slave_mem #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int unsigned              MEM_BYTES     = 12288,
    parameter int unsigned              SECURE_BYTES  = 1024
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                wait_cfg,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr
);

    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam int unsigned OffW  = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [OffW-1:0]         off_q, off_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [Bytes-1:0]        strb_q, strb_d;
    logic [2:0]              prot_q, prot_d;
    logic                    err_q, err_d;
    logic                    mem_we;

    logic [7:0]              mem [MEM_BYTES];
    logic [DATA_WIDTH-1:0]   rd_data;

    // Setup-phase address decode.
    logic                    setup;
    logic [ADDRESS_WIDTH-1:0] setup_off;
    logic [ADDRESS_WIDTH:0]  setup_end;
    logic                    setup_err;

    assign setup     = psel && !penable;
    assign setup_off = paddr - BASE_ADDR;
    // One extra bit so the end-of-access sum cannot wrap past MEM_BYTES.
    assign setup_end = {1'b0, setup_off} + (ADDRESS_WIDTH + 1)'(Bytes);

    always_comb begin
        setup_err = (paddr < BASE_ADDR)
                 || (setup_end > (ADDRESS_WIDTH + 1)'(MEM_BYTES))
                 || ((paddr % ADDRESS_WIDTH'(Bytes)) != '0);
`ifdef APB_SLV_PROT_CHECK_EN
        if (pprot[1] && (setup_off < ADDRESS_WIDTH'(SECURE_BYTES))) begin
            setup_err = 1'b1;
        end
`endif
    end

    // pprot is captured with the rest of the request but not otherwise needed.
    logic unused_prot;
    assign unused_prot = ^prot_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // penable without a preceding setup phase falls through here.
                if (setup) begin
                    off_d   = setup_off[OffW-1:0];
                    write_d = pwrite;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    prot_d  = pprot;
                    err_d   = setup_err;
                    cnt_d   = wait_cfg;
                    state_d = (wait_cfg == 4'd0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (!psel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // Commit on the edge that ends RESP, unless the master aborted.
                mem_we  = psel && write_q && !err_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            err_q   <= err_d;
        end
    end

    // Memory is deliberately not reset; contents survive preset.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int i = 0; i < Bytes; i++) begin
                if (strb_q[i]) begin
                    mem[off_q + OffW'(i)] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Little-endian lane assembly. Out-of-range offsets only occur with err_q
    // set, in which case the value is masked below.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < Bytes; i++) begin
            rd_data[8*i +: 8] = mem[off_q + OffW'(i)];
        end
    end

    // Outputs decode straight from the state flop; dropping psel in RESP
    // squashes the response in the same cycle.
    assign pready  = (state_q == StResp) && psel;
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !write_q && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a vector table for single transfers plus
// hand-written sequences for abort, reset during a transfer and protection.
module tb_apb_slave_mem;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  wait_cfg;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int tests = 0;
    int fails = 0;

    apb_slave_mem dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pprot    (pprot),
        .wait_cfg (wait_cfg),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  wcfg;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    localparam int NumVecs = 15;
    vec_t vecs [NumVecs];

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                                logic [3:0] wcfg, logic [31:0] exp_rdata, logic exp_err,
                                int exp_waits);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.wcfg = wcfg;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_waits = exp_waits;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transfer. waits counts access cycles with pready=0, or -1
    // if pready never arrived within the budget.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [3:0] wcfg, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int waits);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        pstrb = strb; pprot = prot; wait_cfg = wcfg;
        @(negedge pclk);
        penable  = 1'b1;
        wait_cfg = ~wcfg;  // must not affect the transfer already set up
        waits = 0;
        rdata = 'x;
        err   = 1'bx;
        while (!pready && waits < 40) begin
            @(negedge pclk);
            waits++;
        end
        if (pready) begin
            rdata = prdata;
            err   = pslverr;
        end else begin
            waits = -1;
        end
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;
    bit          seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(1, 32'h10,   32'hDEADBEEF, 4'hF, 4'd0,  32'h0,        1'b0, 0);
        vecs[1]  = mk(0, 32'h10,   32'h0,        4'h0, 4'd0,  32'hDEADBEEF, 1'b0, 0);
        vecs[2]  = mk(0, 32'h10,   32'h0,        4'h0, 4'd3,  32'hDEADBEEF, 1'b0, 3);
        vecs[3]  = mk(1, 32'h10,   32'h11223344, 4'h5, 4'd1,  32'h0,        1'b0, 1);
        vecs[4]  = mk(0, 32'h10,   32'h0,        4'h0, 4'd0,  32'hDE22BE44, 1'b0, 0);
        vecs[5]  = mk(0, 32'h3000, 32'h0,        4'h0, 4'd0,  32'h0,        1'b1, 0);
        vecs[6]  = mk(1, 32'h12,   32'hAAAAAAAA, 4'hF, 4'd2,  32'h0,        1'b1, 2);
        vecs[7]  = mk(0, 32'h10,   32'h0,        4'hF, 4'd0,  32'hDE22BE44, 1'b0, 0);
        vecs[8]  = mk(1, 32'h10,   32'hFFFFFFFF, 4'h0, 4'd0,  32'h0,        1'b0, 0);
        vecs[9]  = mk(0, 32'h10,   32'h0,        4'h0, 4'd15, 32'hDE22BE44, 1'b0, 15);
        vecs[10] = mk(1, 32'h2FFC, 32'hCAFEF00D, 4'hF, 4'd0,  32'h0,        1'b0, 0);
        vecs[11] = mk(0, 32'h2FFC, 32'h0,        4'h0, 4'd0,  32'hCAFEF00D, 1'b0, 0);
        vecs[12] = mk(1, 32'h3000, 32'h12345678, 4'hF, 4'd0,  32'h0,        1'b1, 0);
        vecs[13] = mk(0, 32'h2FFE, 32'h0,        4'h0, 4'd1,  32'h0,        1'b1, 1);
        vecs[14] = mk(1, 32'h20,   32'h55AA55AA, 4'hF, 4'd0,  32'h0,        1'b0, 0);

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; wait_cfg = '0;
        #2;
        check("reset pready",  {31'b0, pready},  32'h0);
        check("reset pslverr", {31'b0, pslverr}, 32'h0);
        check("reset prdata",  prdata,           32'h0);
        @(negedge pclk);
        preset = 1'b0;

        for (int i = 0; i < NumVecs; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].wcfg, 3'b000,
                 rd, er, wt);
            check($sformatf("vec%0d waits", i), 32'(wt), 32'(vecs[i].exp_waits));
            check($sformatf("vec%0d pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d prdata", i), rd, vecs[i].exp_rdata);
            end
            @(negedge pclk);
            check($sformatf("vec%0d single pulse", i), {31'b0, pready}, 32'h0);
        end

        // Abort: psel dropped in the 2nd WAIT cycle of a wait_cfg=5 write.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h0;
        pstrb = 4'hF; wait_cfg = 4'd5;
        @(negedge pclk);
        penable = 1'b1;
        check("abort wait1 pready", {31'b0, pready}, 32'h0);
        @(negedge pclk);
        check("abort wait2 pready", {31'b0, pready}, 32'h0);
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge pclk);
            if (pready) seen = 1'b1;
        end
        check("abort no pready", {31'b0, seen}, 32'h0);
        xfer(0, 32'h20, 32'h0, 4'h0, 4'd0, 3'b000, rd, er, wt);
        check("abort mem kept", rd, 32'h55AA55AA);

        // Reset asserted during WAIT.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFFFFFFFF;
        pstrb = 4'hF; wait_cfg = 4'd2;
        @(negedge pclk);
        penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        check("rst wait pready",  {31'b0, pready},  32'h0);
        check("rst wait pslverr", {31'b0, pslverr}, 32'h0);
        check("rst wait prdata",  prdata,           32'h0);
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;

        // Reset asserted during RESP of a read clears outputs asynchronously.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; wait_cfg = 4'd0;
        @(negedge pclk);
        penable = 1'b1;
        check("resp read pready", {31'b0, pready}, 32'h1);
        check("resp read prdata", prdata,          32'h55AA55AA);
        #2 preset = 1'b1;
        #1;
        check("rst resp pready", {31'b0, pready}, 32'h0);
        check("rst resp prdata", prdata,          32'h0);
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;

        // Reset during RESP of a write drops the write.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h0;
        pstrb = 4'hF; wait_cfg = 4'd0;
        @(negedge pclk);
        penable = 1'b1;
        #2 preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer(0, 32'h20, 32'h0, 4'h0, 4'd0, 3'b000, rd, er, wt);
        check("rst write dropped", rd, 32'h55AA55AA);

`ifdef APB_SLV_PROT_CHECK_EN
        xfer(1, 32'h100, 32'h01020304, 4'hF, 4'd0, 3'b000, rd, er, wt);
        check("prot secure write err", {31'b0, er}, 32'h0);
        xfer(1, 32'h100, 32'hA5A5A5A5, 4'hF, 4'd0, 3'b010, rd, er, wt);
        check("prot nonsecure write err", {31'b0, er}, 32'h1);
        xfer(0, 32'h100, 32'h0, 4'h0, 4'd0, 3'b010, rd, er, wt);
        check("prot nonsecure read err", {31'b0, er}, 32'h1);
        check("prot nonsecure read data", rd, 32'h0);
        xfer(0, 32'h100, 32'h0, 4'h0, 4'd0, 3'b000, rd, er, wt);
        check("prot secure read data", rd, 32'h01020304);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
